disp_scan: RTL and testbench
============================

# disp_scan

Time-multiplexed scanner for the eight-digit common-anode seven-segment display on the MIPS IO bus. It holds a 32-bit display value and a control word written by the CPU through memory-mapped stores. It cycles through the digits at a fixed refresh rate, and on each digit it drives the active-low anode select and the 4-bit nibble. The nibble goes directly into the downstream hex-to-segment decoder's `din` input.

## Interface
Parameters:
- `DIGITS`, 8: number of digits scanned. Fixed at 8 for this board; the register layout assumes 8.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit. Minimum 2.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `we`  in  1: write strobe from the IO bus, one cycle wide.
- `addr`  in  1: register select. 0 = DATA, 1 = CTRL.
- `wdata`  in  32: write data.
- `rdata`  out  32: combinational readback of the register selected by `addr`. Unused CTRL bits read 0.
- `digit`  out  4: nibble of the currently selected digit. Feeds the decoder `din`.
- `an`  out  8: anode enables, active-low. Bit i lights digit i; digit 0 is the rightmost.

## Operation
Registers:
- DATA[31:0]: nibble i = DATA[4i+3:4i] is shown on digit i.
- CTRL[7:0] = `mask`, the per-digit enable; 1 = may light.
- CTRL[8] = `lzb`, leading-zero blanking enable.
- Writes update the register selected by `addr` on the edge where `we`=1. A write with `addr`=1 ignores `wdata[31:9]`.

Scan:
- `div` counts 0..SCAN_DIV-1 and wraps.
- When `div`==SCAN_DIV-1, `idx` (3 bits) increments and wraps 7→0.

Blank rule for digit i:
- The digit is blanked if `mask[i]`=0.
- The digit is also blanked if `lzb`=1, i≠0, and DATA nibbles i..7 are all zero.
- Digit 0 is never blanked by `lzb`. The value 0 therefore displays as a single "0".

Output registers, updated every cycle from the current `idx` and registers:
- `digit` ← DATA nibble `idx`.
- `an` ← 8'hFF if digit `idx` is blanked; otherwise all ones except bit `idx`=0.
- `digit` updates even while the digit is blanked. Only `an` gates the display.

Reset values:
- DATA=0, `mask`=8'hFF, `lzb`=0, `div`=0, `idx`=0.
- Outputs `digit`=4'h0, `an`=8'hFF.

Boundary behaviour:
- `mask`=0: `an` stays 8'hFF permanently. The scan continues running.
- A write that coincides with a scan tick: both take effect on the same edge. A write never resets `div` or `idx`.
- `rst` asserted mid-scan: all registers return to reset values on that edge, and any `we` in the same cycle is ignored (reset has priority).
- There is no double-buffering. A DATA write becomes visible on the next output update, so a partially old digit set within one refresh frame is acceptable.

## Timing
- Output latency is one cycle:
  - `digit`/`an` at edge N+1 reflect `idx` and the register values held after edge N.
  - A write on edge N is visible on `digit`/`an` after edge N+1.
- First cycle after reset release: `an`=8'hFE and `digit`=DATA[3:0]=0 appear after one edge.
- Each digit is lit for exactly SCAN_DIV cycles. A full frame is 8×SCAN_DIV cycles.
- `an` never has two or more bits low at the same time.
- `rdata` is combinational from `addr` and the registers, with zero-cycle latency.

## Test plan
Bench uses SCAN_DIV=4.
- **Reset:** hold `rst` 2 cycles, then release. Required: `an`=8'hFF during reset; `an`=8'hFE and `digit`=0 one cycle after release; `idx` advances to 1 after 4 cycles, giving `an`=8'hFD one cycle later.
- **Full scan:** write DATA=32'h89ABCDEF. Required: over 32 cycles, `digit` steps F,E,D,C,B,A,9,8 with `an` FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles; `an` is one-hot-low throughout; the sequence then wraps to digit 0.
- **Leading-zero blanking:** write CTRL=9'h1FF and DATA=32'h00000120. Required: `an` is FE, FD, FB for digits 0–2 and FF for digits 3–7. Then write DATA=0. Required: only digit 0 lights (FE), showing `digit`=0.
- **Mask:** write CTRL=9'h005. Required: only digits 0 and 2 light; all other slots show `an`=FF. Write CTRL=0. Required: `an`=FF for a full 32-cycle frame, and readback of CTRL=0.
- **Simultaneous events:** issue a DATA write on the same edge as a scan tick. Required: `idx` still advances, and the new nibble appears one cycle later. Assert `rst` together with `we`. Required: DATA reads back 0.

Source files
------------

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed scanner for an eight-digit common-anode
// seven-segment display. Holds a CPU-written value and control word, and
// walks the digits at a fixed rate, driving the active-low anodes and the
// nibble for the downstream hex-to-segment decoder.
module disp_scan #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [3:0]        digit,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [31:0]       data_q, data_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              lzb_q, lzb_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [3:0]        digit_q, digit_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [DIGITS-1:0] lead_zero;
  logic              upper_zero;
  logic              blank;

  // lead_zero[i] is set when nibbles i..top are all zero.
  always_comb begin
    upper_zero = 1'b1;
    lead_zero  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (data_q[4*i +: 4] == 4'h0);
      lead_zero[i] = upper_zero;
    end
  end

  // Register writes and scan counter next-state; a write never disturbs the scan.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    lzb_d  = lzb_q;
    if (we) begin
      if (addr) begin
        mask_d = wdata[DIGITS-1:0];
        lzb_d  = wdata[8];
      end else begin
        data_d = wdata;
      end
    end
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivLast) begin
      div_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Output next-state from the current digit; digit 0 is exempt from blanking.
  always_comb begin
    blank   = ~mask_q[idx_q] | (lzb_q & (idx_q != '0) & lead_zero[idx_q]);
    digit_d = data_q[{idx_q, 2'b00} +: 4];
    an_d    = blank ? '1 : ~(DIGITS'(1) << idx_q);
  end

  // State and output registers; reset takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      mask_q  <= '1;
      lzb_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      digit_q <= 4'h0;
      an_q    <= '1;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      lzb_q   <= lzb_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

  // Combinational readback; unused CTRL bits read as zero.
  always_comb begin
    rdata = addr ? {23'h0, lzb_q, mask_q} : data_q;
  end

  assign digit = digit_q;
  assign an    = an_q;

endmodule

// File: tb/tb_disp_scan.sv
// Testbench for disp_scan: a cycle-count reference model predicts each
// output cycle into a queue; a negedge monitor pops and compares.
module tb_disp_scan;

  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [3:0]  digit;
  logic [7:0]  an;

  int checks = 0;
  int failures = 0;

  disp_scan #(
    .DIGITS  (8),
    .SCAN_DIV(ScanDiv)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .digit(digit),
    .an   (an)
  );

  always #5 clk = ~clk;

  // Reference model: registers plus the number of non-reset edges since reset.
  logic [31:0] ref_data;
  logic [7:0]  ref_mask;
  logic        ref_lzb;
  int          ref_cnt;
  bit          model_valid = 1'b0;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] predict();
    int          i;
    bit          blank;
    logic [3:0]  nib;
    logic [7:0]  a;
    i     = (ref_cnt / ScanDiv) % 8;
    nib   = 4'((ref_data >> (4 * i)) & 32'hF);
    blank = (ref_mask[i] == 1'b0) || (ref_lzb && i != 0 && (ref_data >> (4 * i)) == 32'h0);
    a     = blank ? 8'hFF : ~(8'(1) << i);
    return {nib, a};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back({4'h0, 8'hFF});
      ref_data    = 32'h0;
      ref_mask    = 8'hFF;
      ref_lzb     = 1'b0;
      ref_cnt     = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_q.push_back(predict());
      if (we) begin
        if (addr) begin
          ref_mask = wdata[7:0];
          ref_lzb  = wdata[8];
        end else begin
          ref_data = wdata;
        end
      end
      ref_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle is an output cycle for this block.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digit", {28'h0, digit}, {28'h0, e[11:8]});
      check("an", {24'h0, an}, {24'h0, e[7:0]});
      check("an_onehot", {31'h0, ($countones(~an) <= 1)}, 32'h1);
    end
    if (model_valid) begin
      check("rdata", rdata, addr ? {23'h0, ref_lzb, ref_mask} : ref_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick(1);
    we    = 1'b0;
    wdata = $urandom;
  endtask

  initial begin
    // Reset and first scan steps
    tick(2);
    rst = 1'b0;
    tick(10);
    // Full scan
    wr(1'b0, 32'h89ABCDEF);
    tick(40);
    // Leading-zero blanking
    wr(1'b1, 32'h0000_01FF);
    wr(1'b0, 32'h0000_0120);
    tick(36);
    wr(1'b0, 32'h0);
    tick(34);
    // Mask
    wr(1'b1, 32'h0000_0005);
    tick(34);
    wr(1'b1, 32'h0);
    tick(34);
    // Upper CTRL bits ignored; then write on a scan tick
    wr(1'b1, 32'hFFFF_FEFF);
    tick(3);
    for (int k = 0; k < ScanDiv && (ref_cnt % ScanDiv) != ScanDiv - 1; k++) tick(1);
    wr(1'b0, 32'h1234_5678);
    tick(10);
    // Reset together with a write
    rst   = 1'b1;
    we    = 1'b1;
    addr  = 1'b0;
    wdata = 32'hDEAD_BEEF;
    tick(1);
    rst = 1'b0;
    we  = 1'b0;
    tick(6);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        wr(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31));
      end else begin
        addr = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
